bcd_updown_display: RTL and testbench
=====================================

# bcd_updown_display

Parametrised, fully synchronous N-digit BCD up/down counter with an integrated time-multiplexed 7-segment scan driver. It is the next generation of the ripple-clocked decade counter and separate Johnson-counter digit scanner. All state is clocked from one `clk`, so there is no ripple-clock glitching and no garbled latching. The block sits between the front-panel buttons and the shared segment/digit-select pins.

## Interface
Parameters:
- `DIGITS`, default 3: number of BCD digits, 1..8.
- `SCAN_BITS`, default 16: prescaler width; each digit is displayed for 2^SCAN_BITS clk cycles.

Ports:
- `clk` input, 1 bit: system clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `inc_i` input, 1 bit: asynchronous count-up request; rising-edge sensitive.
- `dec_i` input, 1 bit: asynchronous count-down request; rising-edge sensitive.
- `clr_i` input, 1 bit: synchronous clear, level-sensitive, already in the clk domain.
- `count_o` output, 4*DIGITS bits: packed BCD value; digit 0 is in bits [3:0].
- `carry_o` output, 1 bit: one-cycle pulse on an up-count wrap.
- `borrow_o` output, 1 bit: one-cycle pulse on a down-count wrap.
- `dig_sel_o` output, DIGITS bits: one-hot, active-high digit enable.
- `seg_o` output, 7 bits: {G,F,E,D,C,B,A}, active-high segment drive.

## Operation
- Input conditioning:
  - `inc_i` and `dec_i` each pass through a 2-flop synchronizer, then a history flop.
  - Edge pulse is `up = s2 & ~s3`, likewise `dn`; each is exactly 1 cycle per rising edge, however long the input is held.
- Counter update, priority per cycle:
  - `clr_i`: count goes to 0, no pulses.
  - else `up & dn`: no change, no pulses.
  - else `up`: BCD +1.
  - else `dn`: BCD -1.
- BCD arithmetic:
  - Each digit runs 0..9; a digit at 9 incrementing goes to 0 and carries into the next digit.
  - A digit at 0 decrementing goes to 9 and borrows from the next digit.
  - Nibbles A..F are unreachable.
- Wrap behaviour:
  - All-9s +1 gives all-0s and `carry_o`=1 for the following cycle.
  - All-0s -1 gives all-9s and `borrow_o`=1 for the following cycle.
- Scan:
  - A `SCAN_BITS` prescaler free-runs.
  - When the prescaler equals all-ones, `dig_sel_o` rotates left on that edge: digit i goes to i+1, and DIGITS-1 goes to 0.
  - With DIGITS=1, `dig_sel_o` stays at 1.
- Decode:
  - `seg_o` is the combinational decode of the `count_o` nibble selected by `dig_sel_o`.
  - Glyphs: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Unreachable nibbles A-F decode to 77, 7C, 39, 5E, 79, 71.
- `clr_i` does not affect the scan prescaler or `dig_sel_o`.

## Timing
- Reset values, applied immediately on `rst_n` low, independent of `clk`:
  - `count_o`=0, `carry_o`=0, `borrow_o`=0, `dig_sel_o`=1, prescaler=0, synchronizer flops=0, `seg_o`=7'h3F.
- Inputs held high through reset produce no pulse after release. The history flop resets to 0, so for an input already high the synchronizer chain and history flop must load together; implementation must preload all three flops from `inc_i`/`dec_i` on the first edge after release.
- Latency: an `inc_i`/`dec_i` rising edge meeting setup before clk edge E0 updates `count_o` at edge E0+2; `carry_o`/`borrow_o` are high from E0+3 to E0+4.
- `clr_i` high before an edge makes `count_o`=0 after that edge.
- Back-to-back edges: the minimum spacing for each to count is 2 cycles high and 2 cycles low at the input.
- First `dig_sel_o` rotation happens 2^SCAN_BITS edges after reset release, and every 2^SCAN_BITS edges thereafter.
- `seg_o` changes in the same cycle as `count_o` or `dig_sel_o`.
- `rst_n` low mid-scan or mid-count aborts immediately to the reset values; no pulse is emitted.

## Configuration
- `BCD_DISP_BLANK_EN` defined: leading-zero blanking.
  - Digit i>0 shows `seg_o`=0 when it and every higher digit are 0.
  - Digit 0 is never blanked.
  - `dig_sel_o` still scans all digits.
- Not defined: every digit is always displayed.

## Test plan
All scenarios use DIGITS=3, SCAN_BITS=2.
- Reset: hold `rst_n` low with `inc_i` toggling -> `count_o`=12'h000, `dig_sel_o`=3'b001, `seg_o`=7'h3F, `carry_o`=0, `borrow_o`=0; after release, `dig_sel_o` rotates every 4 cycles: 001, 010, 100, 001.
- Up-count: 10 `inc_i` pulses -> 12'h010; 999 pulses total -> 12'h999; one more -> 12'h000 with `carry_o` high for exactly 1 cycle at E0+3.
- Down-count: from 0, one `dec_i` pulse -> 12'h999, `borrow_o` one cycle; then a further pulse -> 12'h998, no borrow.
- Held input and simultaneity: `inc_i` high for 100 cycles -> count +1 only; `inc_i` and `dec_i` rising in the same cycle -> no change, no pulses; `clr_i` together with an `up` pulse -> 12'h000.
- Display at 12'h042: `dig_sel_o`=001 gives `seg_o`=5B, 010 gives 66, 100 gives 3F; with `BCD_DISP_BLANK_EN`, 100 gives 00. At 12'h000, digit 0 gives 3F.
- Reset mid-operation: assert `rst_n` low between `dig_sel_o` rotations with a pulse in flight -> outputs go to reset values within the same cycle, and no count change or pulse occurs after release.

Source files
------------

// File: rtl/bcd_updown_display.sv
// ---------------------------------------------------------------------------
// bcd_updown_display
//
// Fully synchronous N-digit BCD up/down counter with an integrated
// time-multiplexed 7-segment scan driver. Everything runs from one clk.
// There is no ripple clocking anywhere in the block.
//
// Parameters
//   DIGITS     number of BCD digits, 1..8
//   SCAN_BITS  prescaler width; each digit is lit for 2^SCAN_BITS cycles
//
// Ports
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   inc_i      asynchronous count-up request, rising-edge sensitive
//   dec_i      asynchronous count-down request, rising-edge sensitive
//   clr_i      synchronous level-sensitive clear (already in clk domain)
//   count_o    packed BCD value, digit 0 in bits [3:0]
//   carry_o    one-cycle pulse after an up-count wrap (all 9s -> all 0s)
//   borrow_o   one-cycle pulse after a down-count wrap (all 0s -> all 9s)
//   dig_sel_o  one-hot active-high digit enable, rotates left while scanning
//   seg_o      {G,F,E,D,C,B,A} active-high segment drive for the lit digit
//
// Optional feature
//   BCD_DISP_BLANK_EN  when defined, enables leading-zero blanking. A digit
//                      above digit 0 is dark when it and every higher digit
//                      are zero. Scanning itself is unchanged.
// ---------------------------------------------------------------------------
module bcd_updown_display #(
  parameter int DIGITS    = 3,
  parameter int SCAN_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_i,
  input  logic                  dec_i,
  input  logic                  clr_i,
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  carry_o,
  output logic                  borrow_o,
  output logic [DIGITS-1:0]     dig_sel_o,
  output logic [6:0]            seg_o
);

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  // Each request goes through a 2-flop synchronizer, bit [0] and bit [1].
  // It then goes through a history flop, bit [2]. The edge pulse is
  // s2 & ~s3.
  //
  // first_edge is high only on the first clock after reset release. On that
  // edge all three flops load the raw input together. An input that was
  // already held high through reset therefore looks "old" and creates no
  // pulse.
  logic       first_edge;
  logic [2:0] inc_sync;
  logic [2:0] dec_sync;
  logic       up;
  logic       dn;

  // NOTE: sequential state uses non-blocking (<=) assignments only. Every
  // flop then samples the pre-edge values, so the shift chain moves one
  // stage per clock. It does not collapse into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_edge <= 1'b1;
      inc_sync   <= 3'b000;
      dec_sync   <= 3'b000;
    end else begin
      first_edge <= 1'b0;
      if (first_edge) begin
        inc_sync <= {3{inc_i}};
        dec_sync <= {3{dec_i}};
      end else begin
        inc_sync <= {inc_sync[1:0], inc_i};
        dec_sync <= {dec_sync[1:0], dec_i};
      end
    end
  end

  assign up = inc_sync[1] & ~inc_sync[2];
  assign dn = dec_sync[1] & ~dec_sync[2];

  // -------------------------------------------------------------------------
  // BCD +1 / -1 next values
  // -------------------------------------------------------------------------
  // Carry and borrow ripple digit by digit. A 9 rolls to 0 on increment and
  // a 0 rolls to 9 on decrement. If the ripple is still set after the top
  // digit, the whole counter has wrapped.
  logic [4*DIGITS-1:0] count_inc;
  logic [4*DIGITS-1:0] count_dec;
  logic                wrap_up;
  logic                wrap_dn;

  // NOTE: every variable written in this always_comb gets a default on
  // entry. No path can leave a value unassigned, so no latch is inferred.
  always_comb begin
    logic       ci;
    logic       bi;
    logic [3:0] d;
    count_inc = count_o;
    count_dec = count_o;
    ci        = 1'b1;
    bi        = 1'b1;
    d         = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count_o[4*i +: 4];
      if (ci) begin
        if (d == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = d + 4'd1;
          ci = 1'b0;
        end
      end
      if (bi) begin
        if (d == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = d - 4'd1;
          bi = 1'b0;
        end
      end
    end
    wrap_up = ci;
    wrap_dn = bi;
  end

  // -------------------------------------------------------------------------
  // Counter register and wrap pulses
  // -------------------------------------------------------------------------
  // A wrap is recorded on the same edge that updates the count. It is then
  // presented on carry_o/borrow_o one cycle later, for exactly one cycle.
  // Priority on each edge: clear first, then simultaneous up+dn (no
  // change), then up, then dn.
  logic carry_pend;
  logic borrow_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_o     <= '0;
      carry_pend  <= 1'b0;
      borrow_pend <= 1'b0;
      carry_o     <= 1'b0;
      borrow_o    <= 1'b0;
    end else begin
      carry_o     <= carry_pend;
      borrow_o    <= borrow_pend;
      carry_pend  <= 1'b0;
      borrow_pend <= 1'b0;
      if (clr_i) begin
        count_o <= '0;
      end else if (up ^ dn) begin
        if (up) begin
          count_o    <= count_inc;
          carry_pend <= wrap_up;
        end else begin
          count_o     <= count_dec;
          borrow_pend <= wrap_dn;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scan prescaler and digit select
  // -------------------------------------------------------------------------
  // The prescaler free-runs. dig_sel_o steps on the edge where the
  // prescaler wraps from all-ones. clr_i has no effect here.
  logic [SCAN_BITS-1:0] prescale;
  logic [DIGITS-1:0]    dig_sel_next;

  if (DIGITS == 1) begin : g_single
    assign dig_sel_next = 1'b1;
  end else begin : g_rotate
    assign dig_sel_next = {dig_sel_o[DIGITS-2:0], dig_sel_o[DIGITS-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale  <= '0;
      dig_sel_o <= DIGITS'(1);
    end else begin
      prescale <= prescale + SCAN_BITS'(1);
      if (&prescale) begin
        dig_sel_o <= dig_sel_next;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Segment decode
  // -------------------------------------------------------------------------
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = 7'h77;
      4'hB:    glyph = 7'h7C;
      4'hC:    glyph = 7'h39;
      4'hD:    glyph = 7'h5E;
      4'hE:    glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  // The nibble shown is the one whose digit-select bit is set. dig_sel_o is
  // one-hot, so at most one loop iteration matches.
  logic [3:0] shown_nibble;

  always_comb begin
    shown_nibble = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_sel_o[i]) begin
        shown_nibble = count_o[4*i +: 4];
      end
    end
  end

`ifdef BCD_DISP_BLANK_EN
  // Digit i is a leading zero when every nibble from i upward is zero.
  // Digit 0 always stays lit, so a zero count still shows "0".
  logic [DIGITS-1:0] blank_mask;

  always_comb begin
    blank_mask = '0;
    for (int i = 1; i < DIGITS; i++) begin
      blank_mask[i] = ((count_o >> (4*i)) == '0);
    end
  end

  assign seg_o = (|(dig_sel_o & blank_mask)) ? 7'h00 : glyph(shown_nibble);
`else
  assign seg_o = glyph(shown_nibble);
`endif

endmodule

// File: tb/tb_bcd_updown_display.sv
// ---------------------------------------------------------------------------
// tb_bcd_updown_display
//
// Scoreboard bench for bcd_updown_display, with DIGITS=3 and SCAN_BITS=2.
// The reference model is an integer 0..999 that wraps with modulo
// arithmetic. Each issued request pushes the output events it should cause:
// a count change to a new BCD value, a carry pulse, or a borrow pulse.
// A monitor watches the DUT outputs and pops one event for each output
// change it sees. A second process checks dig_sel_o against an edge count
// since reset. Directed sections cover latency and display decode. A random
// section mixes inc, dec, simultaneous and clear requests.
// ---------------------------------------------------------------------------
module tb_bcd_updown_display;

  localparam int DIGITS   = 3;
  localparam int SCAN_LEN = 4;   // 2^SCAN_BITS

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        inc_i = 1'b0;
  logic        dec_i = 1'b0;
  logic        clr_i = 1'b0;
  logic [11:0] count_o;
  logic        carry_o;
  logic        borrow_o;
  logic [2:0]  dig_sel_o;
  logic [6:0]  seg_o;

  always #5 clk = ~clk;

  bcd_updown_display #(.DIGITS(DIGITS), .SCAN_BITS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (inc_i),
    .dec_i     (dec_i),
    .clr_i     (clr_i),
    .count_o   (count_o),
    .carry_o   (carry_o),
    .borrow_o  (borrow_o),
    .dig_sel_o (dig_sel_o),
    .seg_o     (seg_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum logic [1:0] {EV_COUNT, EV_CARRY, EV_BORROW} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [11:0] val;
  } ev_t;

  ev_t sb_q[$];
  int  model    = 0;
  int  edge_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Model step: push the events that should follow, then advance the model.
  task automatic model_step(input bit up, input bit dn, input bit clr);
    int nxt;
    nxt = model;
    if (clr)            nxt = 0;
    else if (up && dn)  nxt = model;
    else if (up)        nxt = (model + 1) % 1000;
    else if (dn)        nxt = (model + 999) % 1000;
    if (nxt != model) sb_q.push_back('{kind: EV_COUNT, val: to_bcd(nxt)});
    if (!clr && up && !dn && model == 999) sb_q.push_back('{kind: EV_CARRY, val: 12'h0});
    if (!clr && dn && !up && model == 0)   sb_q.push_back('{kind: EV_BORROW, val: 12'h0});
    model = nxt;
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic pulse(input bit up, input bit dn, input int hi, input int lo);
    model_step(up, dn, 1'b0);
    inc_i = up;
    dec_i = dn;
    repeat (hi) @(negedge clk);
    inc_i = 1'b0;
    dec_i = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic clear(input int n);
    model_step(1'b0, 1'b0, 1'b1);
    clr_i = 1'b1;
    repeat (n) @(negedge clk);
    clr_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"},   count_o,   12'h000);
    check({tag, "_dig_sel"}, dig_sel_o, 3'b001);
    check({tag, "_seg"},     seg_o,     7'h3F);
    check({tag, "_carry"},   carry_o,   1'b0);
    check({tag, "_borrow"},  borrow_o,  1'b0);
  endtask

  // Display check: the expected digit index comes from the edge count.
  task automatic disp_check(input string tag, input int n);
    int idx, p10, digit;
    logic [6:0] exp;
    repeat (n) begin
      @(negedge clk);
      idx   = (edge_cnt / SCAN_LEN) % DIGITS;
      p10   = (idx == 0) ? 1 : (idx == 1) ? 10 : 100;
      digit = (model / p10) % 10;
      exp   = GLYPH[digit];
`ifdef BCD_DISP_BLANK_EN
      if (idx > 0 && model < p10) exp = 7'h00;
`endif
      check({tag, "_seg"}, seg_o, exp);
    end
  endtask

  task automatic sb_pop(input ev_kind_e k, input logic [11:0] v, input string nm);
    ev_t e;
    check({nm, "_expected"}, sb_q.size() != 0, 1'b1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({nm, "_kind"}, e.kind, k);
      if (k == EV_COUNT) check({nm, "_value"}, v, e.val);
    end
  endtask

  // Edge count since reset release. It is the reference for the scan order.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  always @(negedge clk) begin
    if (rst_n)
      check("dig_sel_scan", dig_sel_o, 3'b001 << ((edge_cnt / SCAN_LEN) % DIGITS));
  end

  // Monitor: each observed output event must match the head of the queue.
  logic [11:0] prev_count  = 12'h000;
  logic        prev_carry  = 1'b0;
  logic        prev_borrow = 1'b0;
  int          carry_run   = 0;
  int          borrow_run  = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (count_o !== prev_count)     sb_pop(EV_COUNT, count_o, "sb_count");
      if (carry_o && !prev_carry)     sb_pop(EV_CARRY, 12'h0, "sb_carry");
      if (borrow_o && !prev_borrow)   sb_pop(EV_BORROW, 12'h0, "sb_borrow");
      if (!carry_o && prev_carry)     check("carry_width", carry_run, 1);
      if (!borrow_o && prev_borrow)   check("borrow_width", borrow_run, 1);
    end
    prev_count  <= count_o;
    prev_carry  <= carry_o;
    prev_borrow <= borrow_o;
    carry_run   <= carry_o ? carry_run + 1 : 0;
    borrow_run  <= borrow_o ? borrow_run + 1 : 0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    // Reset with inc_i toggling; inc_i is left high across release.
    #1 rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      inc_i = ~inc_i;
    end
    inc_i = 1'b1;
    #1 check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model = 0;
    repeat (3) @(negedge clk);
    check("rot_0", dig_sel_o, 3'b001);
    @(negedge clk);
    check("rot_1", dig_sel_o, 3'b010);
    repeat (4) @(negedge clk);
    check("rot_2", dig_sel_o, 3'b100);
    repeat (4) @(negedge clk);
    check("rot_3", dig_sel_o, 3'b001);
    inc_i = 1'b0;
    repeat (4) @(negedge clk);
    check("held_reset_no_pulse", count_o, 12'h000);

    // Up-count.
    repeat (10) pulse(1'b1, 1'b0, 2, 2);
    check("up_10", count_o, 12'h010);
    repeat (989) pulse(1'b1, 1'b0, 2, 2);
    check("up_999", count_o, 12'h999);

    // Wrap, with latency checked edge by edge.
    model_step(1'b1, 1'b0, 1'b0);
    inc_i = 1'b1;
    @(posedge clk);                      // E0
    @(posedge clk); #1;                  // E1
    check("lat_e1_count", count_o, 12'h999);
    @(posedge clk); #1;                  // E2
    check("lat_e2_count", count_o, 12'h000);
    check("lat_e2_carry", carry_o, 1'b0);
    @(posedge clk); #1;                  // E3
    check("lat_e3_carry", carry_o, 1'b1);
    inc_i = 1'b0;
    @(posedge clk); #1;                  // E4
    check("lat_e4_carry", carry_o, 1'b0);
    repeat (2) @(negedge clk);

    // Down-count through zero.
    pulse(1'b0, 1'b1, 2, 3);
    check("dn_wrap", count_o, 12'h999);
    pulse(1'b0, 1'b1, 2, 3);
    check("dn_998", count_o, 12'h998);
    pulse(1'b1, 1'b0, 2, 3);

    // Held input: one count only.
    pulse(1'b1, 1'b1, 2, 2);             // simultaneous: no change
    check("simul_no_change", count_o, 12'h999);
    model_step(1'b1, 1'b0, 1'b0);
    inc_i = 1'b1;
    repeat (100) @(negedge clk);
    inc_i = 1'b0;
    repeat (4) @(negedge clk);
    check("held_plus_one", count_o, 12'h000);

    // Clear together with an up pulse.
    repeat (5) pulse(1'b1, 1'b0, 2, 2);
    model_step(1'b0, 1'b0, 1'b1);
    inc_i = 1'b1;
    clr_i = 1'b1;
    repeat (4) @(negedge clk);
    clr_i = 1'b0;
    inc_i = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_with_up", count_o, 12'h000);

    // Display decode.
    disp_check("disp_000", 12);
    repeat (42) pulse(1'b1, 1'b0, 2, 2);
    check("count_042", count_o, 12'h042);
    disp_check("disp_042", 12);

    // Random mix.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      pulse(1'b1, 1'b0, $urandom_range(2, 4), $urandom_range(2, 4));
      else if (r <= 6) pulse(1'b0, 1'b1, $urandom_range(2, 4), $urandom_range(2, 4));
      else if (r == 7) pulse(1'b1, 1'b1, $urandom_range(2, 4), $urandom_range(2, 4));
      else             clear($urandom_range(1, 2));
    end
    repeat (4) @(negedge clk);
    check("random_final", count_o, to_bcd(model));
    disp_check("disp_random", 12);

    // Reset mid-operation with a pulse in flight.
    if (model == 0) pulse(1'b1, 1'b0, 2, 3);
    inc_i = 1'b1;                        // this request is aborted by reset
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model = 0;
    repeat (3) @(negedge clk);
    inc_i = 1'b0;
    repeat (8) @(negedge clk);
    check("midreset_after", count_o, 12'h000);

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
